// File: rtl/bfly_r2_stage1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bfly_r2_stage1
// Purpose  : First radix-2 butterfly stage of a 512-point block. Each block is
//            32 beats of NCHAN complex lanes. Beats 0-7 and 16-23 are parked
//            in a DIST-deep delay buffer; beats 8-15 and 24-31 are combined
//            with the parked beats (sum out, diff stored), and the stored
//            diffs are streamed out during FILL_B and DRAIN.
// Ports    : clk, rstn (async, active-low)
//            valid_in / in_ready        - input beat handshake
//            data_re_in / data_im_in    - NCHAN x IN_W signed, lane k at
//                                         bits [k*IN_W +: IN_W]
//            data_re_out / data_im_out  - NCHAN x OUT_W signed results
//            valid_out, beat_idx_out    - output beat valid and index 0..31
//            err_drop                   - sticky: beat offered during DRAIN
// Macro    : BFLY1_NJ_ROT_EN - when defined, BFLY_B diffs are rotated by -j
//            (re'=im, im'=-re) before being stored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bfly_r2_stage1 #(
   parameter int NCHAN = 16,
   parameter int IN_W  = 11,
   parameter int OUT_W = 12,
   parameter int DIST  = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   valid_in,
   output logic                   in_ready,
   input  logic [NCHAN*IN_W-1:0]  data_re_in,
   input  logic [NCHAN*IN_W-1:0]  data_im_in,
   output logic [NCHAN*OUT_W-1:0] data_re_out,
   output logic [NCHAN*OUT_W-1:0] data_im_out,
   output logic                   valid_out,
   output logic [4:0]             beat_idx_out,
   output logic                   err_drop
);

   typedef enum logic [2:0] {
      FILL_A = 3'd0,
      BFLY_A = 3'd1,
      FILL_B = 3'd2,
      BFLY_B = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   state_t                  r_state;
   logic [2:0]              r_cnt;

   logic                    w_step;    // FSM advances this cycle
   logic                    w_wr_en;   // delay buffer written this cycle
   logic                    w_out_en;  // an output beat is produced this cycle
   logic [1:0]              w_phase;   // upper two bits of the output beat index
   logic [NCHAN*OUT_W-1:0]  w_res_re;
   logic [NCHAN*OUT_W-1:0]  w_res_im;

   assign in_ready = (r_state != DRAIN);

   // DRAIN steps by itself; every other state steps only on an accepted beat,
   // so an input gap simply stalls the FSM.
   assign w_step   = (valid_in && in_ready) || (r_state == DRAIN);
   assign w_wr_en  = w_step && (r_state != DRAIN);
   assign w_out_en = w_step && (r_state != FILL_A);

   // Output order: BFLY_A sums, FILL_B diffs, BFLY_B sums, DRAIN diffs.
   always_comb begin
      w_phase = 2'd0;
      case (r_state)
         FILL_B:  w_phase = 2'd1;
         BFLY_B:  w_phase = 2'd2;
         DRAIN:   w_phase = 2'd3;
         default: w_phase = 2'd0;
      endcase
   end

   //---------------------------------------------------------------------------
   // Per-lane delay buffer and butterfly arithmetic
   //---------------------------------------------------------------------------
   for (genvar k = 0; k < NCHAN; k++) begin : g_lane
      logic signed [OUT_W-1:0] r_mem_re [DIST];
      logic signed [OUT_W-1:0] r_mem_im [DIST];
      logic signed [OUT_W-1:0] w_in_re, w_in_im;
      logic signed [OUT_W-1:0] w_slot_re, w_slot_im;
      logic signed [OUT_W-1:0] w_sum_re, w_sum_im;
      logic signed [OUT_W-1:0] w_dif_re, w_dif_im;
      logic signed [OUT_W-1:0] w_wr_re, w_wr_im;
      logic signed [OUT_W-1:0] w_out_re, w_out_im;

      assign w_in_re = {{(OUT_W-IN_W){data_re_in[k*IN_W+IN_W-1]}}, data_re_in[k*IN_W +: IN_W]};
      assign w_in_im = {{(OUT_W-IN_W){data_im_in[k*IN_W+IN_W-1]}}, data_im_in[k*IN_W +: IN_W]};

      assign w_slot_re = r_mem_re[r_cnt];
      assign w_slot_im = r_mem_im[r_cnt];

      // One extra bit of headroom makes these exact for IN_W-bit inputs.
      assign w_sum_re = w_slot_re + w_in_re;
      assign w_sum_im = w_slot_im + w_in_im;
      assign w_dif_re = w_slot_re - w_in_re;
      assign w_dif_im = w_slot_im - w_in_im;

      // Default covers FILL_A/FILL_B (store input, FILL_B emits the old slot)
      // and DRAIN (emit slot, no write).
      always_comb begin
         w_wr_re  = w_in_re;
         w_wr_im  = w_in_im;
         w_out_re = w_slot_re;
         w_out_im = w_slot_im;
         case (r_state)
            BFLY_A: begin
               w_out_re = w_sum_re;
               w_out_im = w_sum_im;
               w_wr_re  = w_dif_re;
               w_wr_im  = w_dif_im;
            end
            BFLY_B: begin
               w_out_re = w_sum_re;
               w_out_im = w_sum_im;
`ifdef BFLY1_NJ_ROT_EN
               w_wr_re  = w_dif_im;
               w_wr_im  = -w_dif_re;
`else
               w_wr_re  = w_dif_re;
               w_wr_im  = w_dif_im;
`endif
            end
            default: ;
         endcase
      end

      // Buffer contents are not reset: every slot is written in FILL_A
      // before it is ever read.
      always_ff @(posedge clk) begin
         if (w_wr_en) begin
            r_mem_re[r_cnt] <= w_wr_re;
            r_mem_im[r_cnt] <= w_wr_im;
         end
      end

      assign w_res_re[k*OUT_W +: OUT_W] = w_out_re;
      assign w_res_im[k*OUT_W +: OUT_W] = w_out_im;
   end

   //---------------------------------------------------------------------------
   // FSM, slot counter and registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= FILL_A;
         r_cnt        <= 3'd0;
         valid_out    <= 1'b0;
         beat_idx_out <= 5'd0;
         data_re_out  <= '0;
         data_im_out  <= '0;
         err_drop     <= 1'b0;
      end else begin
         valid_out <= w_out_en;
         if (w_out_en) begin
            data_re_out  <= w_res_re;
            data_im_out  <= w_res_im;
            beat_idx_out <= {w_phase, r_cnt};
         end

         if (valid_in && !in_ready)
            err_drop <= 1'b1;

         if (w_step) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               case (r_state)
                  FILL_A:  r_state <= BFLY_A;
                  BFLY_A:  r_state <= FILL_B;
                  FILL_B:  r_state <= BFLY_B;
                  BFLY_B:  r_state <= DRAIN;
                  default: r_state <= FILL_A;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bfly_r2_stage1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_bfly_r2_stage1
// Purpose  : Self-checking bench for bfly_r2_stage1. A block-level model
//            computes the 32 expected output beats of each 512-sample block
//            directly from the butterfly definition (x[n] +/- x[n+128]).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bfly_r2_stage1;

   localparam int NCHAN = 16;
   localparam int IN_W  = 11;
   localparam int OUT_W = 12;
   localparam int DIST  = 8;
   localparam int IW    = NCHAN*IN_W;
   localparam int OW    = NCHAN*OUT_W;
`ifdef BFLY1_NJ_ROT_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          valid_in = 1'b0;
   logic          in_ready;
   logic [IW-1:0] data_re_in = '0;
   logic [IW-1:0] data_im_in = '0;
   logic [OW-1:0] data_re_out;
   logic [OW-1:0] data_im_out;
   logic          valid_out;
   logic [4:0]    beat_idx_out;
   logic          err_drop;

   bfly_r2_stage1 #(.NCHAN(NCHAN), .IN_W(IN_W), .OUT_W(OUT_W), .DIST(DIST)) dut (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .in_ready(in_ready),
      .data_re_in(data_re_in), .data_im_in(data_im_in),
      .data_re_out(data_re_out), .data_im_out(data_im_out),
      .valid_out(valid_out), .beat_idx_out(beat_idx_out), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Every output beat observed while out of reset
   logic [OW-1:0] q_re [$];
   logic [OW-1:0] q_im [$];
   logic [4:0]    q_idx[$];
   int            q_cyc[$];

   always @(negedge clk) begin
      if (rstn && valid_out) begin
         q_re.push_back(data_re_out);
         q_im.push_back(data_im_out);
         q_idx.push_back(beat_idx_out);
         q_cyc.push_back(cyc);
      end
   end

   // Stimulus block and expected outputs (up to two blocks back to back, or three)
   logic [IW-1:0] blk_re [32];
   logic [IW-1:0] blk_im [32];
   logic [OW-1:0] exp_re [96];
   logic [OW-1:0] exp_im [96];

   function automatic int lane_in(input logic [IW-1:0] v, input int k);
      logic signed [IN_W-1:0] t;
      t = v[k*IN_W +: IN_W];
      return int'(t);
   endfunction

   // Block model: for each half h (samples 0-255, 256-511), output beat j is
   // x[j]+x[j+8] (beats relative to the half), then the 8 diffs x[j]-x[j+8];
   // the second half's diffs are multiplied by -j when rotation is enabled.
   task automatic build_expected(input int off);
      for (int h = 0; h < 2; h++)
         for (int j = 0; j < 8; j++)
            for (int k = 0; k < NCHAN; k++) begin
               int ar, ai, br, bi, dr, di;
               ar = lane_in(blk_re[16*h+j], k);
               ai = lane_in(blk_im[16*h+j], k);
               br = lane_in(blk_re[16*h+8+j], k);
               bi = lane_in(blk_im[16*h+8+j], k);
               dr = ar - br;
               di = ai - bi;
               exp_re[off+16*h+j][k*OUT_W +: OUT_W] = OUT_W'(ar + br);
               exp_im[off+16*h+j][k*OUT_W +: OUT_W] = OUT_W'(ai + bi);
               if (h == 1 && ROT) begin
                  exp_re[off+16*h+8+j][k*OUT_W +: OUT_W] = OUT_W'(di);
                  exp_im[off+16*h+8+j][k*OUT_W +: OUT_W] = OUT_W'(-dr);
               end else begin
                  exp_re[off+16*h+8+j][k*OUT_W +: OUT_W] = OUT_W'(dr);
                  exp_im[off+16*h+8+j][k*OUT_W +: OUT_W] = OUT_W'(di);
               end
            end
   endtask

   task automatic fill_random();
      for (int b = 0; b < 32; b++)
         for (int k = 0; k < NCHAN; k++) begin
            blk_re[b][k*IN_W +: IN_W] = IN_W'($urandom);
            blk_im[b][k*IN_W +: IN_W] = IN_W'($urandom);
         end
   endtask

   task automatic fill_ramp();
      for (int b = 0; b < 32; b++)
         for (int k = 0; k < NCHAN; k++) begin
            blk_re[b][k*IN_W +: IN_W] = IN_W'(b);
            blk_im[b][k*IN_W +: IN_W] = '0;
         end
   endtask

   // mode 0: fill beats 1023, butterfly beats -1024; mode 1: all -1024
   task automatic fill_extreme(input int mode);
      for (int b = 0; b < 32; b++)
         for (int k = 0; k < NCHAN; k++) begin
            if (mode == 0 && (b % 16) < 8) blk_re[b][k*IN_W +: IN_W] = IN_W'(1023);
            else                           blk_re[b][k*IN_W +: IN_W] = IN_W'(-1024);
            blk_im[b][k*IN_W +: IN_W] = '0;
         end
   endtask

   // Present beats 0..nbeats-1 of blk_*; optional idle gap after beat gap_at.
   // Called and returns 1 time unit after a rising edge.
   task automatic drive_block(input int nbeats, input int gap_at, input int gap_len);
      for (int b = 0; b < nbeats; b++) begin
         valid_in   = 1'b1;
         data_re_in = blk_re[b];
         data_im_in = blk_im[b];
         @(posedge clk); #1;
         if (b == gap_at) begin
            valid_in = 1'b0;
            repeat (gap_len) begin @(posedge clk); #1; end
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
   endtask

   // Bounded wait for n beats beyond base, then a few quiet cycles so extra
   // beats would also be seen.
   task automatic wait_outputs(input int base, input int n);
      int t = 0;
      while (q_re.size() < base + n && t < 300) begin @(posedge clk); #1; t++; end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   //---------------------------------------------------------------------------
   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
      n_chk++;
      if (beat_idx_out !== 5'd0) begin n_fail++; $display("FAIL reset beat_idx_out: got %0d want 0", beat_idx_out); end
      n_chk++;
      if (data_re_out !== '0 || data_im_out !== '0) begin
         n_fail++; $display("FAIL reset data: got re=%h im=%h want 0", data_re_out, data_im_out);
      end
      n_chk++;
      if (err_drop !== 1'b0) begin n_fail++; $display("FAIL reset err_drop: got %b want 0", err_drop); end
      @(posedge clk); #1;
      rstn = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_ramp();
      int base;
      wait_ready();
      base = q_re.size();
      fill_ramp(); build_expected(0);
      drive_block(32, -1, 0);
      wait_outputs(base, 32);
      n_chk++;
      if (q_re.size() - base != 32) begin n_fail++; $display("FAIL ramp beat count: got %0d want 32", q_re.size() - base); end
      for (int j = 0; j < 32; j++) begin
         n_chk++;
         if (base + j >= q_re.size()) begin
            n_fail++; $display("FAIL ramp beat %0d: got none want a beat", j);
         end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]) begin
            n_fail++;
            $display("FAIL ramp beat %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                     j, q_idx[base+j], q_re[base+j], q_im[base+j], j, exp_re[j], exp_im[j]);
         end
      end
   endtask

   task automatic test_extremes();
      int base;
      for (int m = 0; m < 2; m++) begin
         wait_ready();
         base = q_re.size();
         fill_extreme(m); build_expected(0);
         drive_block(32, -1, 0);
         wait_outputs(base, 32);
         n_chk++;
         if (q_re.size() - base != 32) begin n_fail++; $display("FAIL extreme%0d beat count: got %0d want 32", m, q_re.size() - base); end
         for (int j = 0; j < 32; j++) begin
            n_chk++;
            if (base + j >= q_re.size()) begin
               n_fail++; $display("FAIL extreme%0d beat %0d: got none want a beat", m, j);
            end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]) begin
               n_fail++;
               $display("FAIL extreme%0d beat %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                        m, j, q_idx[base+j], q_re[base+j], q_im[base+j], j, exp_re[j], exp_im[j]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      wait_ready();
      base = q_re.size();
      for (int b = 0; b < 3; b++) begin
         wait_ready();
         fill_random(); build_expected(32*b);
         drive_block(32, -1, 0);
      end
      wait_outputs(base, 96);
      n_chk++;
      if (q_re.size() - base != 96) begin n_fail++; $display("FAIL b2b beat count: got %0d want 96", q_re.size() - base); end
      for (int j = 0; j < 96; j++) begin
         n_chk++;
         if (base + j >= q_re.size()) begin
            n_fail++; $display("FAIL b2b beat %0d: got none want a beat", j);
         end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]) begin
            n_fail++;
            $display("FAIL b2b beat %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                     j, q_idx[base+j], q_re[base+j], q_im[base+j], 5'(j), exp_re[j], exp_im[j]);
         end
      end
   endtask

   // 3 idle cycles after beat 12: output beats produced by input beats 8..12
   // (indices 0..4) keep their spacing, everything later slips by 3 cycles.
   task automatic test_gap();
      int base, want_dt;
      wait_ready();
      base = q_re.size();
      fill_random(); build_expected(0);
      drive_block(32, 12, 3);
      wait_outputs(base, 32);
      n_chk++;
      if (q_re.size() - base != 32) begin n_fail++; $display("FAIL gap beat count: got %0d want 32", q_re.size() - base); end
      n_chk++;
      if (err_drop !== 1'b0) begin n_fail++; $display("FAIL gap err_drop: got %b want 0", err_drop); end
      for (int j = 0; j < 32; j++) begin
         want_dt = j + ((j >= 5) ? 3 : 0);
         n_chk++;
         if (base + j >= q_re.size()) begin
            n_fail++; $display("FAIL gap beat %0d: got none want a beat", j);
         end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]
                      || q_cyc[base+j] - q_cyc[base] != want_dt) begin
            n_fail++;
            $display("FAIL gap beat %0d: got idx=%0d dt=%0d re=%h im=%h want idx=%0d dt=%0d re=%h im=%h",
                     j, q_idx[base+j], q_cyc[base+j] - q_cyc[base], q_re[base+j], q_im[base+j],
                     j, want_dt, exp_re[j], exp_im[j]);
         end
      end
   endtask

   task automatic test_drop();
      int base;
      wait_ready();
      base = q_re.size();
      n_chk++;
      if (err_drop !== 1'b0) begin n_fail++; $display("FAIL drop err_drop before: got %b want 0", err_drop); end
      fill_random(); build_expected(0);
      drive_block(32, -1, 0);
      // keep offering garbage beats straight through DRAIN
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_re_in = {IW{1'b1}} ^ IW'($urandom);
         data_im_in = IW'($urandom);
         n_chk++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drop in_ready drain cycle %0d: got %b want 0", i, in_ready); end
         @(posedge clk); #1;
      end
      n_chk++;
      if (err_drop !== 1'b1) begin n_fail++; $display("FAIL drop err_drop set: got %b want 1", err_drop); end
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop in_ready after drain: got %b want 1", in_ready); end
      fill_random(); build_expected(32);
      drive_block(32, -1, 0);
      wait_outputs(base, 64);
      n_chk++;
      if (q_re.size() - base != 64) begin n_fail++; $display("FAIL drop beat count: got %0d want 64", q_re.size() - base); end
      for (int j = 0; j < 64; j++) begin
         n_chk++;
         if (base + j >= q_re.size()) begin
            n_fail++; $display("FAIL drop beat %0d: got none want a beat", j);
         end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]) begin
            n_fail++;
            $display("FAIL drop beat %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                     j, q_idx[base+j], q_re[base+j], q_im[base+j], 5'(j), exp_re[j], exp_im[j]);
         end
      end
      n_chk++;
      if (err_drop !== 1'b1) begin n_fail++; $display("FAIL drop err_drop sticky: got %b want 1", err_drop); end
   endtask

   task automatic test_reset_mid();
      int base;
      wait_ready();
      fill_random();
      drive_block(20, -1, 0);
      rstn = 1'b0;
      #1;
      n_chk++;
      if (valid_out !== 1'b0 || beat_idx_out !== 5'd0) begin
         n_fail++; $display("FAIL midreset ctrl: got valid=%b idx=%0d want valid=0 idx=0", valid_out, beat_idx_out);
      end
      n_chk++;
      if (data_re_out !== '0 || data_im_out !== '0) begin
         n_fail++; $display("FAIL midreset data: got re=%h im=%h want 0", data_re_out, data_im_out);
      end
      n_chk++;
      if (err_drop !== 1'b0) begin n_fail++; $display("FAIL midreset err_drop: got %b want 0", err_drop); end
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset in_ready: got %b want 1", in_ready); end
      base = q_re.size();
      fill_random(); build_expected(0);
      @(posedge clk); #1;
      drive_block(32, -1, 0);
      wait_outputs(base, 32);
      n_chk++;
      if (q_re.size() - base != 32) begin n_fail++; $display("FAIL midreset beat count: got %0d want 32", q_re.size() - base); end
      for (int j = 0; j < 32; j++) begin
         n_chk++;
         if (base + j >= q_re.size()) begin
            n_fail++; $display("FAIL midreset beat %0d: got none want a beat", j);
         end else if (q_idx[base+j] !== 5'(j) || q_re[base+j] !== exp_re[j] || q_im[base+j] !== exp_im[j]) begin
            n_fail++;
            $display("FAIL midreset beat %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                     j, q_idx[base+j], q_re[base+j], q_im[base+j], j, exp_re[j], exp_im[j]);
         end
      end
   endtask

   //---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_ramp();
      test_extremes();
      test_back_to_back();
      test_gap();
      test_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit reached, want end of sequence");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
